// File: rtl/game_pkg.sv
// Shared game definitions: top-level game-state codes, hit-FSM state
// encodings and small saturating helpers used by the hit manager.
package game_pkg;

    localparam int CLK_HZ = 25000000;

    // Top-level game-state encodings
    localparam logic [1:0] GS_IDLE    = 2'b00;
    localparam logic [1:0] GS_RUNNING = 2'b01;
    localparam logic [1:0] GS_WIN     = 2'b10;
    localparam logic [1:0] GS_CLEAN   = 2'b11;

    // Hit-FSM state type and encodings
    typedef logic [2:0] hit_state_t;
    localparam hit_state_t HS_ALIVE   = 3'd0;
    localparam hit_state_t HS_CONFIRM = 3'd1;
    localparam hit_state_t HS_HIT     = 3'd2;
    localparam hit_state_t HS_INVULN  = 3'd3;
    localparam hit_state_t HS_DEAD    = 3'd4;

    // Lives after one hit; floors at zero
    function automatic logic [3:0] lives_after_hit(input logic [3:0] lives);
        return (lives == 4'd0) ? 4'd0 : lives - 4'd1;
    endfunction

    // Hit counter increment that sticks at 255
    function automatic logic [7:0] hits_after_hit(input logic [7:0] hits);
        return (hits == 8'hFF) ? hits : hits + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter. done is high while the count sits at zero; a load
// of N-1 therefore gives a done flag N enabled cycles after the load.
module pulse_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority over counting; the counter rests at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/hit_manager.sv
// Turns the raw car/raccoon overlap flag into confirmed hits, tracks lives,
// runs the post-hit invulnerability window with sprite blink, issues the
// respawn pulse and latches game over. All outputs are registered.
module hit_manager
    import game_pkg::*;
#(
    parameter int C_LIVES_INIT     = 3,
    parameter int C_CONFIRM_CYCLES = 4,
    parameter int C_INVULN_CYCLES  = CLK_HZ,
    parameter int C_BLINK_CYCLES   = CLK_HZ / 8
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Running,
    input  logic       i_Collision,
    output logic [3:0] o_Lives,
    output logic       o_Respawn,
    output logic       o_Invulnerable,
    output logic       o_Blink,
    output logic       o_Game_Over,
    output logic [7:0] o_Hit_Count
);

    localparam int IW = $clog2(C_INVULN_CYCLES + 1);
    localparam int BW = (C_BLINK_CYCLES > 1) ? $clog2(C_BLINK_CYCLES) : 1;
    // Timers are loaded with N-1 so they flag done on the Nth cycle
    localparam logic [IW-1:0] INVULN_LOAD = IW'(C_INVULN_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LOAD  = BW'(C_BLINK_CYCLES - 1);

    hit_state_t state;
    logic [7:0] confirm_count;
    logic [3:0] lives;
    logic [7:0] hit_count;
    logic       respawn;
    logic       invulnerable;
    logic       blink;
    logic       game_over;

    logic       hit_is_fatal;
    logic       invuln_load;
    logic       invuln_enable;
    logic       invuln_done;
    logic       blink_load;
    logic       blink_enable;
    logic       blink_done;

    // Timer controls: both start on a survivable hit; blink reloads each half-period
    always_comb begin
        hit_is_fatal  = (lives_after_hit(lives) == 4'd0);
        invuln_load   = (state == HS_HIT) && !hit_is_fatal;
        invuln_enable = (state == HS_INVULN);
        blink_enable  = (state == HS_INVULN);
        blink_load    = invuln_load || ((state == HS_INVULN) && blink_done);
    end

    pulse_timer #(
        .WIDTH(IW)
    ) u_invuln_timer (
        .clk       (i_Clk),
        .reset     (i_Reset),
        .load      (invuln_load),
        .load_value(INVULN_LOAD),
        .enable    (invuln_enable),
        .done      (invuln_done)
    );

    pulse_timer #(
        .WIDTH(BW)
    ) u_blink_timer (
        .clk       (i_Clk),
        .reset     (i_Reset),
        .load      (blink_load),
        .load_value(BLINK_LOAD),
        .enable    (blink_enable),
        .done      (blink_done)
    );

    // Hit FSM with registered lives, counters and status outputs
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state         <= HS_ALIVE;
            confirm_count <= 8'd0;
            lives         <= 4'(C_LIVES_INIT);
            hit_count     <= 8'd0;
            respawn       <= 1'b0;
            invulnerable  <= 1'b0;
            blink         <= 1'b1;
            game_over     <= 1'b0;
        end else begin
            respawn <= 1'b0;
            case (state)
                HS_ALIVE: begin
                    if (i_Running && i_Collision) begin
                        if (C_CONFIRM_CYCLES == 1) begin
                            state <= HS_HIT;
                        end else begin
                            state         <= HS_CONFIRM;
                            confirm_count <= 8'd1;
                        end
                    end
                end
                HS_CONFIRM: begin
                    if (i_Running && i_Collision) begin
                        if (({1'b0, confirm_count} + 9'd1) >= 9'(C_CONFIRM_CYCLES)) begin
                            state         <= HS_HIT;
                            confirm_count <= 8'd0;
                        end else begin
                            confirm_count <= confirm_count + 8'd1;
                        end
                    end else begin
                        state         <= HS_ALIVE;
                        confirm_count <= 8'd0;
                    end
                end
                HS_HIT: begin
                    lives     <= lives_after_hit(lives);
                    hit_count <= hits_after_hit(hit_count);
                    if (hit_is_fatal) begin
                        state     <= HS_DEAD;
                        game_over <= 1'b1;
                    end else begin
                        state        <= HS_INVULN;
                        respawn      <= 1'b1;
                        invulnerable <= 1'b1;
                        blink        <= 1'b0;
                    end
                end
                HS_INVULN: begin
                    // Collision is ignored here, including on the exit cycle
                    if (invuln_done) begin
                        state        <= HS_ALIVE;
                        invulnerable <= 1'b0;
                        blink        <= 1'b1;
                    end else if (blink_done) begin
                        blink <= ~blink;
                    end
                end
                HS_DEAD: begin
                    invulnerable <= 1'b0;
                    blink        <= 1'b1;
                end
                default: begin
                    state <= HS_ALIVE;
                end
            endcase
        end
    end

    assign o_Lives        = lives;
    assign o_Respawn      = respawn;
    assign o_Invulnerable = invulnerable;
    assign o_Blink        = blink;
    assign o_Game_Over    = game_over;
    assign o_Hit_Count    = hit_count;

endmodule

// File: tb/tb_hit_manager.sv
// Bench for hit_manager: an event/time-based reference model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_hit_manager;

    localparam int LIVES  = 3;
    localparam int CONF   = 4;
    localparam int INV    = 20;
    localparam int BLINK  = 5;

    logic       clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Running = 1'b0;
    logic       i_Collision = 1'b0;
    logic [3:0] o_Lives;
    logic       o_Respawn;
    logic       o_Invulnerable;
    logic       o_Blink;
    logic       o_Game_Over;
    logic [7:0] o_Hit_Count;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    hit_manager #(
        .C_LIVES_INIT    (LIVES),
        .C_CONFIRM_CYCLES(CONF),
        .C_INVULN_CYCLES (INV),
        .C_BLINK_CYCLES  (BLINK)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (i_Reset),
        .i_Running     (i_Running),
        .i_Collision   (i_Collision),
        .o_Lives       (o_Lives),
        .o_Respawn     (o_Respawn),
        .o_Invulnerable(o_Invulnerable),
        .o_Blink       (o_Blink),
        .o_Game_Over   (o_Game_Over),
        .o_Hit_Count   (o_Hit_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: hits are scheduled events, invulnerability is a time
    // window measured from the hit edge, blink phase is derived from elapsed time.
    int  cyc_n     = 0;
    int  m_lives   = LIVES;
    int  m_hits    = 0;
    bit  m_over    = 0;
    bit  m_resp    = 0;
    bit  m_inv     = 0;
    bit  m_blink   = 1;
    int  streak    = 0;
    int  hit_at    = -1;
    int  inv_start = 0;

    always @(posedge clk) begin
        cyc_n++;
        if (i_Reset) begin
            m_lives = LIVES; m_hits = 0; m_over = 0; m_resp = 0;
            m_inv = 0; m_blink = 1; streak = 0; hit_at = -1;
        end else begin
            m_resp = 0;
            if (hit_at == cyc_n) begin
                hit_at  = -1;
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                if (m_hits < 255) m_hits++;
                if (m_lives == 0) m_over = 1;
                else begin
                    m_resp = 1; m_inv = 1; inv_start = cyc_n;
                end
            end else if (m_over) begin
                streak = 0;
            end else if (m_inv) begin
                if (cyc_n - inv_start >= INV) m_inv = 0;
            end else if (i_Running && i_Collision) begin
                streak++;
                if (streak >= CONF) begin
                    streak = 0;
                    hit_at = cyc_n + 1;
                end
            end else begin
                streak = 0;
            end
            m_blink = m_inv ? (((cyc_n - inv_start) / BLINK) % 2 == 1) : 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("lives",     int'(o_Lives),        m_lives);
            chk("respawn",   int'(o_Respawn),      int'(m_resp));
            chk("invuln",    int'(o_Invulnerable), int'(m_inv));
            chk("blink",     int'(o_Blink),        int'(m_blink));
            chk("game_over", int'(o_Game_Over),    int'(m_over));
            chk("hit_count", int'(o_Hit_Count),    m_hits);
        end
    end

    // Apply inputs, then sample just after the next rising edge
    task automatic tick(input bit run, input bit coll, input bit rst);
        i_Running   = run;
        i_Collision = coll;
        i_Reset     = rst;
        @(posedge clk);
        #1;
    endtask

    int lat, resp_cnt, inv_cnt, tog_cnt, t1, t2, t3, lives_prev;
    bit prev_inv, prev_blink, first_inv_blink_seen;
    bit coll_r;
    int burst;

    initial begin
        // Reset state
        tick(0, 0, 1);
        tick(0, 0, 1);
        cmp_en = 1'b1;
        chk("rst_lives",     int'(o_Lives), 3);
        chk("rst_respawn",   int'(o_Respawn), 0);
        chk("rst_invuln",    int'(o_Invulnerable), 0);
        chk("rst_blink",     int'(o_Blink), 1);
        chk("rst_game_over", int'(o_Game_Over), 0);
        chk("rst_hit_count", int'(o_Hit_Count), 0);

        // 1: short glitch does not register
        resp_cnt = 0;
        for (int i = 0; i < 3; i++) begin tick(1, 1, 0); resp_cnt += int'(o_Respawn); end
        for (int i = 0; i < 5; i++) begin tick(1, 0, 0); resp_cnt += int'(o_Respawn); end
        chk("t1_lives", int'(o_Lives), 3);
        chk("t1_respawn_pulses", resp_cnt, 0);
        chk("t1_hit_count", int'(o_Hit_Count), 0);

        // 2: one confirmed hit, invulnerability and blink
        lat = -1; resp_cnt = 0; inv_cnt = 0; tog_cnt = 0;
        prev_inv = 0; prev_blink = 1; first_inv_blink_seen = 0;
        for (int i = 1; i <= 35; i++) begin
            tick(1, (i <= 10), 0);
            if (lat < 0 && o_Lives == 4'd2) lat = i;
            resp_cnt += int'(o_Respawn);
            inv_cnt  += int'(o_Invulnerable);
            if (o_Invulnerable && !prev_inv) begin
                chk("t2_blink_on_entry", int'(o_Blink), 0);
                first_inv_blink_seen = 1;
            end
            if (o_Invulnerable && prev_inv && (o_Blink != prev_blink)) tog_cnt++;
            prev_inv = o_Invulnerable; prev_blink = o_Blink;
        end
        chk("t2_latency", lat, 5);
        chk("t2_respawn_pulses", resp_cnt, 1);
        chk("t2_invuln_cycles", inv_cnt, 20);
        chk("t2_blink_toggles", tog_cnt, 3);
        chk("t2_entry_seen", int'(first_inv_blink_seen), 1);
        chk("t2_hit_count", int'(o_Hit_Count), 1);
        chk("t2_blink_after", int'(o_Blink), 1);

        // 3: held collision drains all lives
        tick(1, 0, 1);
        t1 = -1; t2 = -1; t3 = -1; resp_cnt = 0; lives_prev = 3;
        for (int i = 1; i <= 200; i++) begin
            tick(1, 1, 0);
            resp_cnt += int'(o_Respawn);
            if (int'(o_Lives) != lives_prev) begin
                if (o_Lives == 4'd2) t1 = i;
                if (o_Lives == 4'd1) t2 = i;
                if (o_Lives == 4'd0) t3 = i;
                lives_prev = int'(o_Lives);
            end
        end
        chk("t3_first_hit", t1, 5);
        chk("t3_spacing_a", t2 - t1, 25);
        chk("t3_spacing_b", t3 - t2, 25);
        chk("t3_respawn_pulses", resp_cnt, 2);
        chk("t3_lives", int'(o_Lives), 0);
        chk("t3_game_over", int'(o_Game_Over), 1);
        chk("t3_hit_count", int'(o_Hit_Count), 3);

        // 4: not running, collision ignored
        tick(1, 0, 1);
        inv_cnt = 0;
        for (int i = 0; i < 50; i++) begin tick(0, 1, 0); inv_cnt += int'(o_Invulnerable); end
        chk("t4_lives", int'(o_Lives), 3);
        chk("t4_hit_count", int'(o_Hit_Count), 0);
        chk("t4_invuln_cycles", inv_cnt, 0);

        // 5: reset in the middle of invulnerability
        tick(1, 0, 1);
        for (int i = 0; i < 5; i++) tick(1, 1, 0);
        for (int i = 0; i < 9; i++) tick(1, 0, 0);
        chk("t5_pre_invuln", int'(o_Invulnerable), 1);
        tick(1, 0, 1);
        chk("t5_lives", int'(o_Lives), 3);
        chk("t5_invuln", int'(o_Invulnerable), 0);
        chk("t5_blink", int'(o_Blink), 1);
        chk("t5_hit_count", int'(o_Hit_Count), 0);

        // 6: game over is frozen until reset
        for (int i = 0; i < 80; i++) tick(1, 1, 0);
        for (int i = 0; i < 40; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        chk("t6_lives", int'(o_Lives), 0);
        chk("t6_game_over", int'(o_Game_Over), 1);
        chk("t6_hit_count", int'(o_Hit_Count), 3);
        tick(1, 0, 1);
        chk("t6_reset_lives", int'(o_Lives), 3);
        chk("t6_reset_game_over", int'(o_Game_Over), 0);

        // Random bursts of collision with occasional stalls and resets
        coll_r = 0; burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0) begin
                coll_r = ~coll_r;
                burst  = $urandom_range(1, 9);
            end
            burst--;
            tick(($urandom_range(0, 19) != 0), coll_r, ($urandom_range(0, 399) == 0));
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
